// File: rtl/trap_unit.sv
// trap_unit: exception/trap controller for the multicycle RISC-V core.
// Collects sticky cause requests, takes the lowest-indexed enabled one,
// saves EPC/cause/trap value, redirects the PC to a direct or vectored
// handler and services the return request.
module trap_unit #(
    parameter int              XLEN       = 32'd64,
    parameter int              NCAUSE     = 32'd4,
    parameter int              CW         = 32'd4,
    parameter logic [XLEN-1:0] VEC_BASE   = 64'h0000_0000_0000_00FF,
    parameter int              VEC_STRIDE = 32'd4,
    parameter int              RET_OFS    = 32'd4,
    parameter int              CNT_W      = 32'd16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCAUSE-1:0] cause_req,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   tval_in,
    input  logic              ret_req,
    input  logic              vec_mode,
    input  logic              cfg_we,
    input  logic [NCAUSE-1:0] cfg_mask,
    output logic              pc_load,
    output logic [XLEN-1:0]   trap_pc,
    output logic [XLEN-1:0]   epc_out,
    output logic [CW-1:0]     cause_out,
    output logic [XLEN-1:0]   tval_out,
    output logic              in_trap,
    output logic [NCAUSE-1:0] pending,
    output logic [CNT_W-1:0]  trap_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HANDLER  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [NCAUSE-1:0] pending_r;
    logic [NCAUSE-1:0] mask_r;
    logic [NCAUSE-1:0] eligible_s;
    logic [NCAUSE-1:0] clr_s;
    logic [CW-1:0]     sel_s;
    logic [XLEN-1:0]   epc_r;
    logic [XLEN-1:0]   tval_r;
    logic [CW-1:0]     cause_r;
    logic [CNT_W-1:0]  count_r;
    logic              in_trap_r;
    logic              pc_load_s;
    logic [XLEN-1:0]   trap_pc_s;

    // Lowest set index of a cause vector; zero when nothing is set.
    function automatic logic [CW-1:0] lowest_idx(input logic [NCAUSE-1:0] v);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            idx = v[i] ? CW'(i) : idx;
        end
        return idx;
    endfunction

    // Pick the cause to take and the pending bit it retires in CAPTURE.
    always_comb begin
        eligible_s = pending_r & mask_r;
        sel_s      = lowest_idx(eligible_s);
        clr_s      = {NCAUSE{1'b0}};
        for (int i = 0; i < NCAUSE; i++) begin
            clr_s[i] = (state_r == ST_CAPTURE) && (|eligible_s) && (sel_s == CW'(i));
        end
    end

    // Next-state logic plus the combinational PC redirect path.
    always_comb begin
        state_next_s = state_r;
        pc_load_s    = 1'b0;
        trap_pc_s    = {XLEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_next_s = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_load_s    = 1'b1;
                state_next_s = ST_HANDLER;
                if (vec_mode) begin
                    trap_pc_s = VEC_BASE + (XLEN'(VEC_STRIDE) * XLEN'(cause_r));
                end else begin
                    trap_pc_s = VEC_BASE;
                end
            end
            ST_HANDLER: begin
                if (ret_req) begin
                    pc_load_s    = 1'b1;
                    trap_pc_s    = epc_r + XLEN'(RET_OFS);
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HANDLER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register; in_trap follows the state it will be in next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            in_trap_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            in_trap_r <= (state_next_s == ST_HANDLER);
        end
    end

    // Sticky pending causes (new requests win over retirement) and the enable mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= {NCAUSE{1'b0}};
            mask_r    <= {NCAUSE{1'b1}};
        end else begin
            pending_r <= (pending_r & ~clr_s) | cause_req;
            if (cfg_we) begin
                mask_r <= cfg_mask;
            end
        end
    end

    // Trap context capture and saturating count of taken traps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_r   <= {XLEN{1'b0}};
            tval_r  <= {XLEN{1'b0}};
            cause_r <= {CW{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_CAPTURE) begin
            epc_r   <= pc_in;
            tval_r  <= tval_in;
            cause_r <= sel_s;
            if (count_r != {CNT_W{1'b1}}) begin
                count_r <= count_r + CNT_W'(1'b1);
            end
        end
    end

    assign pc_load    = pc_load_s;
    assign trap_pc    = trap_pc_s;
    assign epc_out    = epc_r;
    assign cause_out  = cause_r;
    assign tval_out   = tval_r;
    assign in_trap    = in_trap_r;
    assign pending    = pending_r;
    assign trap_count = count_r;

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Parametrised exception/trap controller for the multicycle RISC-V core; supersedes the fixed EPC and single-bit cause registers.
- Latches up to NCAUSE sticky cause requests from the control unit and selects the lowest-indexed enabled one.
- Captures EPC, cause code and trap value, then redirects PC to a direct or vectored handler address.
- Services the return request and counts taken traps.

Parameters:
XLEN, 64, datapath/PC width
NCAUSE, 4, number of cause request lines (1..16)
CW, 4, cause code width, must satisfy 2**CW >= NCAUSE
VEC_BASE, 64'h0000_0000_0000_00FF, handler base address
VEC_STRIDE, 4, byte stride between vectored entries
RET_OFS, 4, byte offset added to EPC on return
CNT_W, 16, trap counter width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
cause_req  in  NCAUSE  per-cause event pulses from control unit
pc_in  in  XLEN  current PC (PC register output)
tval_in  in  XLEN  faulting address/instruction for trap value
ret_req  in  1  return-from-trap pulse (mret decode)
vec_mode  in  1  0 = direct (all traps to VEC_BASE), 1 = vectored
cfg_we  in  1  write enable for cause mask
cfg_mask  in  NCAUSE  new cause enable mask
pc_load  out  1  one-cycle request to load PC with trap_pc
trap_pc  out  XLEN  PC redirect value
epc_out  out  XLEN  saved exception PC
cause_out  out  CW  saved cause code
tval_out  out  XLEN  saved trap value
in_trap  out  1  high while the handler runs
pending  out  NCAUSE  sticky pending causes
trap_count  out  CNT_W  saturating count of taken traps

Behaviour:
- Reset (reset low, async) values:
  - state IDLE; pending = 0; cause mask = all ones.
  - epc_out, tval_out, trap_pc = 0; cause_out = 0.
  - pc_load = 0, in_trap = 0, trap_count = 0.
- Pending: each cycle pending <= (pending & ~clr) | cause_req. Set wins over clear for the same bit in the same cycle. Masked causes stay pending but are never selected.
- Selection: eligible = pending & mask. Selected cause = lowest set index of eligible.
- cfg_we writes the mask at the clock edge in any state. A write in IDLE affects selection from the next cycle.
- FSM, registered, 4 states:
  - IDLE: if eligible != 0, go to CAPTURE.
  - CAPTURE (1 cycle):
    - epc_out <= pc_in; tval_out <= tval_in; cause_out <= selected index.
    - Clear the selected pending bit.
    - trap_count increments and saturates at 2**CNT_W-1.
    - Go to REDIRECT.
  - REDIRECT (1 cycle):
    - pc_load = 1.
    - trap_pc = VEC_BASE when vec_mode = 0; VEC_BASE + VEC_STRIDE*cause_out when vec_mode = 1. Arithmetic is XLEN-bit and wraps modulo 2**XLEN.
    - vec_mode is sampled in this cycle.
    - Go to HANDLER.
  - HANDLER:
    - in_trap = 1. No nesting: new causes accumulate in pending but are not taken.
    - On ret_req: pc_load = 1 and trap_pc = epc_out + RET_OFS (wraps) in the same cycle, via a combinational pc_load/trap_pc path; go to IDLE.
- ret_req outside HANDLER is ignored: no pc_load, no state change.
- ret_req together with cause_req in HANDLER: return is taken, cause becomes pending, and the trap is entered via CAPTURE on the cycle after IDLE is reached.
- Latency:
  - Cause pulse at edge N → pending visible after N.
  - CAPTURE at N+1 (IDLE sees eligible during cycle N+1), REDIRECT pc_load at N+2, in_trap at N+3.
- Outputs other than pc_load/trap_pc are registered. pc_load is 0 in IDLE, CAPTURE, and in HANDLER without ret_req.
- Reset asserted mid-operation returns to IDLE with all reset values. Any in-flight pc_load is dropped.

Test Plan:
- Reset, then cause_req = 4'b0100 for 1 cycle with pc_in = 64'h40, tval_in = 64'h1234, vec_mode = 1 → CAPTURE, then REDIRECT with pc_load = 1, trap_pc = 64'hFF+8 = 64'h107; epc_out = 64'h40, cause_out = 2, tval_out = 64'h1234, trap_count = 1.
- In HANDLER, assert ret_req → same cycle pc_load = 1, trap_pc = 64'h44; next cycle in_trap = 0, state IDLE.
- cause_req = 4'b1010 simultaneously, vec_mode = 0 → cause 1 taken, trap_pc = 64'hFF; pending = 4'b1000 remains. After ret_req, cause 3 is taken automatically (cause_out = 3).
- cfg_mask = 4'b1110 then cause_req = 4'b0001 → pending[0] = 1, no pc_load for 10 cycles. Writing mask 4'b1111 → trap taken with cause_out = 0.
- cause_req pulse during HANDLER with no ret_req → no pc_load, pending bit set, in_trap held. ret_req while IDLE → ignored.
- reset low during REDIRECT → pc_load = 0 immediately, all outputs at reset values. Also: CNT_W = 2 instance saturates trap_count at 3 after 5 traps.
